// File: rtl/inst_fetch_align.sv
// Fetch/align stage: issues word-aligned fetches, buffers returned halfwords and
// presents one RVC or 32-bit instruction (possibly word-straddling) per handshake.
module inst_fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_compressed,
  output logic [31:0] out_pc
);

  localparam logic [31:0] RESET_FETCH = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] RESET_HEAD  = {RESET_PC[31:1], 1'b0};

  logic [15:0] hw_q [4];
  logic [15:0] hw_d [4];
  logic [15:0] shifted [4];
  logic [2:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        outstanding_q, outstanding_d;
  logic        drop_q, drop_d;
  logic        skip_lo_q, skip_lo_d;

  logic        head_compressed;
  logic        consume;
  logic        resp;
  logic [2:0]  consumed;
  logic [2:0]  base;

  assign head_compressed = (hw_q[0][1:0] != 2'b11);
  assign out_valid       = head_compressed ? (count_q >= 3'd1) : (count_q >= 3'd2);
  assign out_compressed  = out_valid & head_compressed;
  assign out_inst        = !out_valid      ? 32'h0 :
                           head_compressed ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
  assign out_pc          = head_pc_q;

  // Never request while in reset, so the first request lands right after release.
  assign mem_req  = rst_n & !outstanding_q & !redirect & (count_q <= 3'd2);
  assign mem_addr = fetch_addr_q;

  always_comb begin
    consume  = out_valid & out_ready & !redirect;
    resp     = mem_valid & outstanding_q;
    consumed = consume ? (head_compressed ? 3'd1 : 3'd2) : 3'd0;
    base     = count_q - consumed;

    case (consumed)
      3'd1:    shifted = '{hw_q[1], hw_q[2], hw_q[3], 16'h0000};
      3'd2:    shifted = '{hw_q[2], hw_q[3], 16'h0000, 16'h0000};
      default: shifted = hw_q;
    endcase

    hw_d          = shifted;
    count_d       = base;
    head_pc_d     = head_pc_q + {28'h0, consumed, 1'b0};
    fetch_addr_d  = fetch_addr_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    skip_lo_d     = skip_lo_q;

    if (mem_req) begin
      outstanding_d = 1'b1;
      fetch_addr_d  = fetch_addr_q + 32'd4;
    end

    // Responses land behind whatever survived this cycle's consume.
    if (resp) begin
      outstanding_d = 1'b0;
      if (drop_q) begin
        drop_d = 1'b0;
      end else if (skip_lo_q) begin
        skip_lo_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (int'(base) == i) hw_d[i] = mem_rdata[31:16];
        end
        count_d = base + 3'd1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (int'(base) == i)     hw_d[i] = mem_rdata[15:0];
          if (int'(base) + 1 == i) hw_d[i] = mem_rdata[31:16];
        end
        count_d = base + 3'd2;
      end
    end

    if (redirect) begin
      hw_d          = hw_q;
      count_d       = 3'd0;
      head_pc_d     = redirect_pc & ~32'h1;
      fetch_addr_d  = redirect_pc & ~32'h3;
      skip_lo_d     = redirect_pc[1];
      outstanding_d = outstanding_q & !mem_valid;
      drop_d        = outstanding_q & !mem_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_q          <= '{default: 16'h0000};
      count_q       <= 3'd0;
      head_pc_q     <= RESET_HEAD;
      fetch_addr_q  <= RESET_FETCH;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      skip_lo_q     <= RESET_PC[1];
    end else begin
      hw_q          <= hw_d;
      count_q       <= count_d;
      head_pc_q     <= head_pc_d;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      skip_lo_q     <= skip_lo_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_align.sv
// Bench for inst_fetch_align: word memory model plus a queue of expected
// instructions popped on each output handshake.
module tb_inst_fetch_align;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memValid = 1'b0;
  logic [31:0] memRdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] outInst;
  logic        outCompressed;
  logic [31:0] outPc;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
  } exp_t;

  exp_t        expQ [$];
  exp_t        exp;
  logic [31:0] mem [256];
  logic        memHold = 1'b0;
  logic        pendValid = 1'b0;
  logic [31:0] pendAddr = 32'h0;
  int          checks = 0;
  int          errors = 0;

  inst_fetch_align #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rstN),
    .mem_req(memReq), .mem_addr(memAddr), .mem_valid(memValid), .mem_rdata(memRdata),
    .redirect(redirect), .redirect_pc(redirectPc),
    .out_valid(outValid), .out_ready(outReady), .out_inst(outInst),
    .out_compressed(outCompressed), .out_pc(outPc)
  );

  always #5 clk = ~clk;

  // One-cycle memory; memHold parks the request so it can arrive late.
  always @(posedge clk) begin
    memValid <= 1'b0;
    if (memReq && !memHold) begin
      memValid  <= 1'b1;
      memRdata  <= mem[memAddr[9:2]];
      pendValid <= 1'b0;
    end else if (memReq) begin
      pendValid <= 1'b1;
      pendAddr  <= memAddr;
    end else if (pendValid && !memHold) begin
      memValid  <= 1'b1;
      memRdata  <= mem[pendAddr[9:2]];
      pendValid <= 1'b0;
    end
  end

  function automatic logic [31:0] stallWord(input int i);
    return 32'h0000_0093 | (32'(i) << 20);
  endfunction

  function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc, input logic comp);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    e.comp = comp;
    return e;
  endfunction

  task automatic applyReset(input logic holdMem, input logic ready);
    rstN       = 1'b0;
    redirect   = 1'b0;
    redirectPc = 32'h0;
    outReady   = ready;
    memHold    = holdMem;
    expQ.delete();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    applyReset(1'b0, 1'b1);
    mem[0] = 32'h0041_0113;
    expQ.push_back(mk(32'h0041_0113, 32'h0, 1'b0));
    checks++;
    if (memReq !== 1'b0 || memAddr !== 32'h0 || outValid !== 1'b0 || outInst !== 32'h0 ||
        outCompressed !== 1'b0 || outPc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs req=%b addr=%h v=%b inst=%h c=%b pc=%h required 0,0,0,0,0,0",
               memReq, memAddr, outValid, outInst, outCompressed, outPc);
    end
    rstN = 1'b1;
    #1;
    checks++;
    if (memReq !== 1'b1 || memAddr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL first_req req=%b addr=%h required 1,00000000", memReq, memAddr);
    end
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL early_valid got=%b required 0", outValid);
    end
    @(negedge clk);
    checks++;
    if (outValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_valid got=%b required 1", outValid);
    end else begin
      exp = expQ.pop_front();
      checks++;
      if (outInst !== exp.inst || outPc !== exp.pc || outCompressed !== exp.comp) begin
        errors++;
        $display("[TB] FAIL reset_first got %h@%h c=%b required %h@%h c=%b",
                 outInst, outPc, outCompressed, exp.inst, exp.pc, exp.comp);
      end
    end
  endtask

  task automatic test_rvc_pair;
    applyReset(1'b0, 1'b1);
    mem[0] = 32'h4505_0505;
    expQ.push_back(mk(32'h0000_0505, 32'h0, 1'b1));
    expQ.push_back(mk(32'h0000_4505, 32'h2, 1'b1));
    rstN = 1'b1;
    for (int c = 0; c < 40 && expQ.size() > 0; c++) begin
      @(negedge clk);
      if (outValid && outReady) begin
        exp = expQ.pop_front();
        checks++;
        if (outInst !== exp.inst || outPc !== exp.pc || outCompressed !== exp.comp) begin
          errors++;
          $display("[TB] FAIL rvc_pair got %h@%h c=%b required %h@%h c=%b",
                   outInst, outPc, outCompressed, exp.inst, exp.pc, exp.comp);
        end
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL rvc_pair_timeout left=%0d required 0", expQ.size());
    end
  endtask

  task automatic test_straddle;
    applyReset(1'b0, 1'b1);
    mem[0] = 32'h0113_0001;
    mem[1] = 32'h0001_0041;
    expQ.push_back(mk(32'h0000_0001, 32'h0, 1'b1));
    expQ.push_back(mk(32'h0041_0113, 32'h2, 1'b0));
    expQ.push_back(mk(32'h0000_0001, 32'h6, 1'b1));
    rstN = 1'b1;
    for (int c = 0; c < 40 && expQ.size() > 0; c++) begin
      @(negedge clk);
      if (outValid && outReady) begin
        exp = expQ.pop_front();
        checks++;
        if (outInst !== exp.inst || outPc !== exp.pc || outCompressed !== exp.comp) begin
          errors++;
          $display("[TB] FAIL straddle got %h@%h c=%b required %h@%h c=%b",
                   outInst, outPc, outCompressed, exp.inst, exp.pc, exp.comp);
        end
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL straddle_timeout left=%0d required 0", expQ.size());
    end
  endtask

  task automatic test_redirect;
    logic found;
    applyReset(1'b1, 1'b1);
    mem[0]  = 32'h0001_0001;
    mem[65] = 32'h4505_1111;
    mem[66] = 32'h0041_0113;
    expQ.push_back(mk(32'h0000_4505, 32'h106, 1'b1));
    expQ.push_back(mk(32'h0041_0113, 32'h108, 1'b0));
    rstN = 1'b1;
    @(negedge clk);
    redirect   = 1'b1;
    redirectPc = 32'h0000_0106;
    @(negedge clk);
    redirect = 1'b0;
    memHold  = 1'b0;
    checks++;
    if (outValid !== 1'b0 || outPc !== 32'h106) begin
      errors++;
      $display("[TB] FAIL redirect_head v=%b pc=%h required 0,00000106", outValid, outPc);
    end
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = memReq;
    end
    checks++;
    if (!found || memAddr !== 32'h104) begin
      errors++;
      $display("[TB] FAIL redirect_addr req=%b addr=%h required 1,00000104", found, memAddr);
    end
    for (int c = 0; c < 40 && expQ.size() > 0; c++) begin
      @(negedge clk);
      if (outValid && outReady) begin
        exp = expQ.pop_front();
        checks++;
        if (outInst !== exp.inst || outPc !== exp.pc || outCompressed !== exp.comp) begin
          errors++;
          $display("[TB] FAIL redirect got %h@%h c=%b required %h@%h c=%b",
                   outInst, outPc, outCompressed, exp.inst, exp.pc, exp.comp);
        end
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL redirect_timeout left=%0d required 0", expQ.size());
    end
  endtask

  task automatic test_stall;
    applyReset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      mem[i] = stallWord(i);
      expQ.push_back(mk(stallWord(i), 32'(4 * i), 1'b0));
    end
    rstN = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (outValid) begin
        checks++;
        if (outInst !== stallWord(0) || outPc !== 32'h0 || outCompressed !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stall_hold got %h@%h required %h@00000000",
                   outInst, outPc, stallWord(0));
        end
      end
    end
    checks++;
    if (outValid !== 1'b1 || memReq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_saturate v=%b req=%b required 1,0", outValid, memReq);
    end
    outReady = 1'b1;
    for (int c = 0; c < 40 && expQ.size() > 0; c++) begin
      if (c > 0) @(negedge clk);
      if (outValid && outReady) begin
        exp = expQ.pop_front();
        checks++;
        if (outInst !== exp.inst || outPc !== exp.pc || outCompressed !== exp.comp) begin
          errors++;
          $display("[TB] FAIL stall_release got %h@%h c=%b required %h@%h c=%b",
                   outInst, outPc, outCompressed, exp.inst, exp.pc, exp.comp);
        end
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL stall_timeout left=%0d required 0", expQ.size());
    end
  endtask

  task automatic test_reset_midfetch;
    logic seen;
    applyReset(1'b0, 1'b0);
    mem[0] = 32'h4505_0505;
    mem[1] = 32'h5678_1234;
    expQ.push_back(mk(32'h0000_0505, 32'h0, 1'b1));
    expQ.push_back(mk(32'h0000_4505, 32'h2, 1'b1));
    rstN = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = outValid;
    end
    memHold = 1'b1;
    @(negedge clk);
    checks++;
    if (!seen || outValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_fill v=%b required 1", outValid);
    end
    rstN    = 1'b0;
    memHold = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0 || memReq !== 1'b0 || outPc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_clear v=%b req=%b pc=%h required 0,0,00000000",
               outValid, memReq, outPc);
    end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checks++;
    if (memReq !== 1'b1 || memAddr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_restart req=%b addr=%h required 1,00000000", memReq, memAddr);
    end
    outReady = 1'b1;
    for (int c = 0; c < 40 && expQ.size() > 0; c++) begin
      @(negedge clk);
      if (outValid && outReady) begin
        exp = expQ.pop_front();
        checks++;
        if (outInst !== exp.inst || outPc !== exp.pc || outCompressed !== exp.comp) begin
          errors++;
          $display("[TB] FAIL midreset got %h@%h c=%b required %h@%h c=%b",
                   outInst, outPc, outCompressed, exp.inst, exp.pc, exp.comp);
        end
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL midreset_timeout left=%0d required 0", expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_rvc_pair();
    test_straddle();
    test_redirect();
    test_stall();
    test_reset_midfetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
